orient_hist_ctrl: RTL

ORIENT_HIST_CTRL -- requirements
Module: orient_hist_ctrl

---
 rtl/orient_hist_ctrl_if.sv | 28 ++
 rtl/orient_hist_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/orient_hist_ctrl_if.sv
// Sample stream bundle for the orientation histogram controller.
// The producer (master) offers angle/magnitude samples; the controller
// (slave) accepts one whenever s_valid and s_ready are both high.
interface orient_hist_ctrl_if #(
    parameter int MAG_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_angle;
    logic [MAG_W-1:0] s_mag;
    logic             s_last;

    modport master (
        output s_valid,
        output s_angle,
        output s_mag,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_angle,
        input  s_mag,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/orient_hist_ctrl.sv
// Orientation histogram controller.
// Builds a 32-bin histogram of gradient magnitudes indexed by direction
// (angle mapped to a bin by an external combinational ROM), then scans it
// for the largest bin. Samples go through a two-stage pipeline: stage 1
// latches the ROM bin and magnitude, stage 2 adds into the bin with
// saturation. Because stage 2 reads the bin array directly, a sample to the
// same bin one cycle later always sees the freshly written value.
module orient_hist_ctrl #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    orient_hist_ctrl_if.slave s,
    output logic [7:0]       rom_a,
    input  logic [4:0]       rom_spo,
    output logic             busy,
    output logic             done,
    output logic [4:0]       peak_bin,
    output logic [ACC_W-1:0] peak_val
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [ACC_W-1:0] hist [32];

    logic             s1_valid;
    logic [4:0]       s1_bin;
    logic [MAG_W-1:0] s1_mag;

    logic [5:0]       scan_idx;
    logic [ACC_W-1:0] max_val;
    logic [4:0]       max_idx;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] add_sat;

    assign rom_a     = s.s_angle;
    assign s.s_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign accept  = ready_q & s.s_valid;
    assign sum_ext = {1'b0, hist[s1_bin]} + {{(ACC_W + 1 - MAG_W){1'b0}}, s1_mag};
    assign add_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    // Histogram storage plus the accept (stage 1) and saturating add (stage 2) pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                hist[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_bin   <= '0;
            s1_mag   <= '0;
        end else if (state == CLEAR) begin
            for (int i = 0; i < 32; i++) begin
                hist[i] <= '0;
            end
            s1_valid <= 1'b0;
        end else begin
            if (s1_valid) begin
                hist[s1_bin] <= add_sat;
            end
            s1_valid <= accept;
            if (accept) begin
                s1_bin <= rom_spo;
                s1_mag <= s.s_mag;
            end
        end
    end

    // Run sequencing, maximum search and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            scan_idx <= '0;
            max_val  <= '0;
            max_idx  <= '0;
            peak_bin <= '0;
            peak_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CLEAR;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    max_val <= '0;
                    max_idx <= '0;
                    state   <= ACCUM;
                    ready_q <= 1'b1;
                end
                ACCUM: begin
                    if (accept && s.s_last) begin
                        state   <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    scan_idx <= '0;
                    state    <= SCAN;
                end
                SCAN: begin
                    if (!scan_idx[5]) begin
                        if (hist[scan_idx[4:0]] > max_val) begin
                            max_val <= hist[scan_idx[4:0]];
                            max_idx <= scan_idx[4:0];
                        end
                        scan_idx <= scan_idx + 6'd1;
                    end else begin
                        peak_bin <= max_idx;
                        peak_val <= max_val;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
